spi_write_port: RTL

SPI slave front end that turns host write frames on Sclk/Mosi/Csel into word-wide write requests for the video memory arbiter. It oversamples the SPI pins in the MemClk domain and decodes a command/address/data frame. Decoded (address, data) pairs are queued in a small FIFO and presented on a valid/ack handshake that drives the arbiter's write request source (address and write data). This block sits directly upstream of vmmu and is the only path by which external pixel data reaches memory.

---
 rtl/spi_write_port_pkg.sv | 15 +
 rtl/spi_write_port_if.sv | 13 +
 rtl/spi_write_fifo.sv | 46 ++++
 rtl/spi_write_port.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/spi_write_port_pkg.sv
// Shared types and constants for the SPI write port: FSM encoding, write command, address field size.
package spi_write_port_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CMD    = 3'd1,
    ADDR   = 3'd2,
    DATA   = 3'd3,
    IGNORE = 3'd4
  } state_t;

  localparam logic [7:0] CMD_WRITE  = 8'h02;
  localparam int         ADDR_BYTES = 3;

endpackage

// File: rtl/spi_write_port_if.sv
// Write-request handshake toward the memory arbiter: head entry plus valid (WriteReq) / accept (WriteAck).
interface spi_write_port_if #(
  parameter int AWIDTH = 19,
  parameter int DWIDTH = 8
);
  logic              WriteReq;
  logic              WriteAck;
  logic [AWIDTH-1:0] WriteAddr;
  logic [DWIDTH-1:0] WriteData;

  modport master (output WriteReq, WriteAddr, WriteData, input WriteAck);
  modport slave  (input WriteReq, WriteAddr, WriteData, output WriteAck);
endinterface

// File: rtl/spi_write_fifo.sv
// Small synchronous FIFO; head is shown combinationally and held at the last popped value while empty.
// A push while full is accepted only when a pop happens in the same cycle.
module spi_write_fifo #(
  parameter int WIDTH = 27,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0]      wr_ptr, rd_ptr;
  logic [WIDTH-1:0] hold;
  logic             do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? hold : mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PW-1:0]] <= push_dat;
  end

  // hold tracks the head so the outputs stay put once the last entry is popped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      hold   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (!empty)  hold   <= mem[rd_ptr[PW-1:0]];
    end
  end

endmodule

// File: rtl/spi_write_port.sv
// SPI slave (mode 0) oversampled on MemClk; decodes cmd 0x02 + 24-bit address + data into queued write requests.
// SPI_WRITE_PORT_BURST_EN: queue every data byte with auto-incrementing address; otherwise only the first byte.
module spi_write_port
  import spi_write_port_pkg::*;
#(
  parameter int AWIDTH = 19,
  parameter int DWIDTH = 8,
  parameter int FDEPTH = 4
) (
  input  logic             MemClk,
  input  logic             RstN,
  input  logic             Sclk,
  input  logic             Mosi,
  input  logic             Csel,
  spi_write_port_if.master wr,
  output logic             Busy,
  output logic             Overflow
);
  localparam int EW    = AWIDTH + DWIDTH;
  localparam int ABITS = ADDR_BYTES * 8;

  logic [2:0]        sclk_sync;
  logic [1:0]        mosi_sync, csel_sync, rst_pipe;
  logic              csel_d;
  state_t            state, state_nxt;
  logic [4:0]        bit_cnt;
  logic [AWIDTH-2:0] shreg;
  logic [AWIDTH-1:0] shreg_nxt, cur_addr;
  logic              push_vld;
  logic [EW-1:0]     push_dat, head;
  logic              bit_rise, bit_clr, bit_inc, addr_ld, byte_push;
  logic              fifo_full, fifo_empty, pop;

  always_ff @(posedge MemClk or negedge RstN) begin
    if (!RstN) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      csel_sync <= 2'b11;
      rst_pipe  <= '0;
      csel_d    <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[1:0], Sclk};
      mosi_sync <= {mosi_sync[0], Mosi};
      csel_sync <= {csel_sync[0], Csel};
      rst_pipe  <= {rst_pipe[0], 1'b1};
      // stays 0 until a real high Csel is seen, so a low Csel at reset release is not a falling edge
      csel_d    <= rst_pipe[1] & csel_sync[1];
    end
  end

  assign bit_rise  = sclk_sync[1] & ~sclk_sync[2];
  assign shreg_nxt = {shreg, mosi_sync[1]};
  assign Busy      = ~csel_sync[1];

  always_comb begin
    state_nxt = state;
    bit_clr   = 1'b0;
    bit_inc   = 1'b0;
    addr_ld   = 1'b0;
    byte_push = 1'b0;
    if (csel_sync[1]) begin
      state_nxt = IDLE;
      bit_clr   = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = csel_d ? CMD : IGNORE;
          bit_clr   = 1'b1;
        end
        CMD: begin
          bit_inc = bit_rise;
          if (bit_rise && bit_cnt == 5'd7) begin
            state_nxt = (shreg_nxt[7:0] == CMD_WRITE) ? ADDR : IGNORE;
            bit_clr   = 1'b1;
          end
        end
        ADDR: begin
          bit_inc = bit_rise;
          if (bit_rise && bit_cnt == 5'(ABITS - 1)) begin
            state_nxt = DATA;
            addr_ld   = 1'b1;
            bit_clr   = 1'b1;
          end
        end
        DATA: begin
          bit_inc = bit_rise;
          if (bit_rise && bit_cnt == 5'd7) begin
            byte_push = 1'b1;
            bit_clr   = 1'b1;
`ifndef SPI_WRITE_PORT_BURST_EN
            state_nxt = IGNORE;
`endif
          end
        end
        default: bit_clr = 1'b1;
      endcase
    end
  end

  always_ff @(posedge MemClk or negedge RstN) begin
    if (!RstN) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      shreg    <= '0;
      cur_addr <= '0;
      push_vld <= 1'b0;
      push_dat <= '0;
      Overflow <= 1'b0;
    end else begin
      state    <= state_nxt;
      push_vld <= byte_push;
      if (bit_clr)      bit_cnt <= '0;
      else if (bit_inc) bit_cnt <= bit_cnt + 5'd1;
      if (bit_rise)     shreg   <= shreg_nxt[AWIDTH-2:0];
      if (addr_ld)      cur_addr <= shreg_nxt;
      if (byte_push) begin
        push_dat <= {cur_addr, shreg_nxt[DWIDTH-1:0]};
`ifdef SPI_WRITE_PORT_BURST_EN
        cur_addr <= cur_addr + 1'b1;
`endif
      end
      if (push_vld && fifo_full && !pop) Overflow <= 1'b1;
    end
  end

  assign pop = ~fifo_empty & wr.WriteAck;

  spi_write_fifo #(.WIDTH(EW), .DEPTH(FDEPTH)) u_fifo (
    .clk      (MemClk),
    .rst_n    (RstN),
    .push     (push_vld),
    .push_dat (push_dat),
    .pop      (pop),
    .head     (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign wr.WriteReq  = ~fifo_empty;
  assign wr.WriteAddr = head[EW-1:DWIDTH];
  assign wr.WriteData = head[DWIDTH-1:0];

endmodule
